feature_channel_arbiter: RTL and testbench
==========================================

FEATURE_CHANNEL_ARBITER -- requirements
Module: feature_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, meaning the number of FFT frame sources sharing one feature_extractor.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of frames in flight inside the extractor (power of 2).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_in input 1 system clock; rst_n_in input 1 async active-low reset.
REQ-004 ch_fft_data_in  input  [NUM_CHANNELS][32]  per-channel FFT samples.
REQ-005 ch_fft_valid_in / ch_fft_last_in  input  [NUM_CHANNELS]  per-channel valid / frame-last.
REQ-006 ch_fft_ready_out  output  [NUM_CHANNELS]  per-channel ready.
REQ-007 ext_fft_data_out 32, ext_fft_valid_out 1, ext_fft_last_out 1  output  muxed stream to extractor; ext_fft_ready_in  input 1.
REQ-008 ext_feature_data_in signed 16, ext_feature_valid_in 1, ext_feature_last_in 1  input  extractor output; ext_feature_ready_out  output 1.
REQ-009 feature_data_out signed 16, feature_valid_out 1, feature_last_out 1, feature_channel_out $clog2(NUM_CHANNELS)  output  tagged features; feature_ready_in  input 1.
REQ-010 tag_error_out  output 1  sticky: feature arrived with no outstanding tag.
REQ-011 frames_done_out  output  [NUM_CHANNELS][16]  per-channel completed-frame counters.

Function
REQ-012 SHALL run FSM states IDLE, STREAM.
REQ-013 IDLE: if tag FIFO not full and any ch_fft_valid_in high, SHALL grant the first valid channel searching round-robin from last_grant+1 (mod NUM_CHANNELS), push its index into the tag FIFO, go STREAM next cycle.
REQ-014 IDLE with tag FIFO full SHALL grant nothing; all ch_fft_ready_out low.
REQ-015 STREAM: ext_fft_* SHALL combinationally mirror the granted channel; ch_fft_ready_out[grant] = ext_fft_ready_in; all other ready low.
REQ-016 STREAM: on ext_fft_valid_out && ext_fft_ready_in && ext_fft_last_out SHALL return to IDLE and set last_grant = grant; frame switch only on frame boundaries.
REQ-017 In IDLE ext_fft_valid_out SHALL be 0; one idle cycle between frames (grant latency 1 cycle).
REQ-018 Feature path SHALL be combinational: feature_data/valid/last_out = ext_feature_*_in; ext_feature_ready_out = feature_ready_in; feature_channel_out = tag FIFO head.
REQ-019 Tag SHALL pop on feature_valid_out && feature_ready_in && feature_last_out.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; push when full SHALL never occur (REQ-014).
REQ-021 ext_feature_valid_in high with tag FIFO empty SHALL set tag_error_out, force feature_valid_out 0, keep ext_feature_ready_out high (drop data), no pop.
REQ-022 Occupancy counter width $clog2(TAG_DEPTH)+1; pointers wrap modulo TAG_DEPTH.

Reset
REQ-023 rst_n_in low SHALL asynchronously set: state IDLE, last_grant NUM_CHANNELS-1 (so channel 0 wins first), tag FIFO empty, tag_error_out 0, frames_done_out 0, all ch_fft_ready_out 0, ext_fft_valid_out 0.
REQ-024 Reset mid-frame SHALL discard the partial frame and all outstanding tags; upstream resend is the sources' responsibility.

Configuration
REQ-025 Macro FEATURE_ARB_FRAME_COUNT_EN defined: frames_done_out[c] SHALL increment (wrap 0xFFFF->0) on each tag pop whose tag is c.
REQ-026 Macro undefined: frames_done_out SHALL be constant 0 and no counter registers synthesized.

Structure
REQ-027 Shared package feature_pkg SHALL hold the FSM state enum, FFT_W=32, FEATURE_W=16, and the channel-index typedef.
REQ-028 Tag storage SHALL be one sub-module tag_fifo (parameterised depth/width, push/pop/full/empty/head).

Verification
REQ-029 Both channels valid after reset, 512-sample frames -> ch0 granted first, then ch1, then ch0; one idle cycle between frames.
REQ-030 Only ch1 valid for 3 frames -> ch1 granted 3 times consecutively; ch0 ready stays 0.
REQ-031 Extractor stalls outputs, 4 frames pushed -> 5th frame not granted until one 16-feature burst with last completes; feature_channel_out matches push order.
REQ-032 Push and pop in same cycle at occupancy 2 -> occupancy remains 2.
REQ-033 ext_feature_valid_in pulsed with no frames sent -> tag_error_out 1 and stays 1; feature_valid_out 0.
REQ-034 rst_n_in low mid-STREAM (sample 200) -> outputs reset immediately without clock; with FEATURE_ARB_FRAME_COUNT_EN, after 3 ch0 bursts frames_done_out[0]=3.

Source files
------------

// File: rtl/feature_channel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// feature_pkg
// Shared types and widths for the feature channel arbiter.
//   FFT_W       : width of one FFT sample word on the frame streams
//   FEATURE_W   : width of one signed feature word from the extractor
//   ch_idx_t    : integer-sized channel index used for round-robin search
//   arb_state_e : arbiter FSM state
// -----------------------------------------------------------------------------
package feature_pkg;

    localparam int FFT_W     = 32;
    localparam int FEATURE_W = 16;

    typedef int unsigned ch_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } arb_state_e;

endpackage

// File: rtl/feature_channel_arbiter_if.sv
// -----------------------------------------------------------------------------
// Interfaces for the feature channel arbiter.
//   feature_tag_if    : tag FIFO access (push/pop/push_data in, full/empty/head out)
//                       master = arbiter side, slave = tag_fifo side
//   feature_stream_if : generic valid/ready/last stream of W-bit words
//                       master = producer, slave = consumer
// -----------------------------------------------------------------------------
interface feature_tag_if #(
    parameter int W = 1
);
    logic         push;
    logic         pop;
    logic [W-1:0] push_data;
    logic         full;
    logic         empty;
    logic [W-1:0] head;

    modport master (output push, pop, push_data, input full, empty, head);
    modport slave  (input push, pop, push_data, output full, empty, head);
endinterface

interface feature_stream_if #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/feature_channel_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Small FIFO holding the channel index of every frame currently inside the
// extractor, so features coming back can be tagged with their source.
// Ports:
//   clk_in, rst_n_in : clock, async active-low reset (empties the FIFO)
//   tq (slave)       : push/pop/push_data in; full/empty/head out
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    feature_tag_if.slave tq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign tq.full  = (count_q == FULL_CNT);
    assign tq.empty = (count_q == '0);
    assign tq.head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = tq.push && !tq.full;
        do_pop   = tq.pop && !tq.empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = tq.push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // push and pop together leave occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/feature_channel_arbiter.sv
// -----------------------------------------------------------------------------
// feature_channel_arbiter
// Shares one feature extractor between NUM_CHANNELS FFT frame sources.
// Whole frames are granted round-robin; the granted channel index is pushed
// into a tag FIFO so the extractor's feature bursts (one burst per frame,
// ended by last) come back tagged with their source channel.
// Ports:
//   clk_in, rst_n_in            : clock, async active-low reset
//   ch_fft_*                    : per-channel frame streams in (data/valid/last, ready out)
//   ext_fft_*                   : muxed frame stream to the extractor
//   ext_feature_*               : feature stream from the extractor
//   feature_*                   : tagged feature stream out (feature_channel_out = tag)
//   tag_error_out               : sticky, feature arrived with no outstanding tag
//   frames_done_out             : per-channel completed-frame counters
// Optional feature: define FEATURE_ARB_FRAME_COUNT_EN to build the per-channel
// frame counters; otherwise frames_done_out is tied to zero.
// -----------------------------------------------------------------------------
module feature_channel_arbiter
    import feature_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int TAG_DEPTH    = 4,
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic [NUM_CHANNELS-1:0][FFT_W-1:0]    ch_fft_data_in,
    input  logic [NUM_CHANNELS-1:0]               ch_fft_valid_in,
    input  logic [NUM_CHANNELS-1:0]               ch_fft_last_in,
    output logic [NUM_CHANNELS-1:0]               ch_fft_ready_out,
    output logic [FFT_W-1:0]                      ext_fft_data_out,
    output logic                                  ext_fft_valid_out,
    output logic                                  ext_fft_last_out,
    input  logic                                  ext_fft_ready_in,
    input  logic signed [FEATURE_W-1:0]           ext_feature_data_in,
    input  logic                                  ext_feature_valid_in,
    input  logic                                  ext_feature_last_in,
    output logic                                  ext_feature_ready_out,
    output logic signed [FEATURE_W-1:0]           feature_data_out,
    output logic                                  feature_valid_out,
    output logic                                  feature_last_out,
    output logic [CH_W-1:0]                       feature_channel_out,
    input  logic                                  feature_ready_in,
    output logic                                  tag_error_out,
    output logic [NUM_CHANNELS-1:0][15:0]         frames_done_out
);

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic            tag_error_q, tag_error_d;

    logic            pick_found;
    logic [CH_W-1:0] pick_idx;
    ch_idx_t         cand;
    logic            tag_push;
    logic            tag_pop;

    feature_tag_if #(.W(CH_W)) tq ();

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (CH_W)
    ) u_tag_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tq       (tq.slave)
    );

    // ---------------- frame arbitration FSM ----------------
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        tag_push          = 1'b0;
        ch_fft_ready_out  = '0;
        ext_fft_data_out  = '0;
        ext_fft_valid_out = 1'b0;
        ext_fft_last_out  = 1'b0;
        pick_found        = 1'b0;
        pick_idx          = '0;
        cand              = '0;

        // Search starts one past the last winner so every channel gets a turn.
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            cand = ch_idx_t'((int'(last_grant_q) + i) % NUM_CHANNELS);
            if (!pick_found && ch_fft_valid_in[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CH_W-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A full tag FIFO blocks new grants; the push can never overflow.
                if (pick_found && !tq.full) begin
                    grant_d  = pick_idx;
                    tag_push = 1'b1;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ext_fft_data_out           = ch_fft_data_in[grant_q];
                ext_fft_valid_out          = ch_fft_valid_in[grant_q];
                ext_fft_last_out           = ch_fft_last_in[grant_q];
                ch_fft_ready_out[grant_q]  = ext_fft_ready_in;
                if (ext_fft_valid_out && ext_fft_ready_in && ext_fft_last_out) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- feature return path ----------------
    // With no outstanding tag the feature is unattributable: flag it, hide it
    // downstream and keep ready high so the extractor does not hang.
    assign feature_data_out      = ext_feature_data_in;
    assign feature_last_out      = ext_feature_last_in;
    assign feature_valid_out     = ext_feature_valid_in && !tq.empty;
    assign ext_feature_ready_out = tq.empty ? 1'b1 : feature_ready_in;
    assign feature_channel_out   = tq.head;
    assign tag_pop               = feature_valid_out && feature_ready_in && feature_last_out;
    assign tag_error_out         = tag_error_q;

    assign tq.push      = tag_push;
    assign tq.push_data = pick_idx;
    assign tq.pop       = tag_pop;

    always_comb begin
        tag_error_d = tag_error_q | (ext_feature_valid_in & tq.empty);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CHANNELS - 1);
            tag_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tag_error_q  <= tag_error_d;
        end
    end

    // ---------------- optional per-channel frame counters ----------------
`ifdef FEATURE_ARB_FRAME_COUNT_EN
    logic [NUM_CHANNELS-1:0][15:0] frames_done_q, frames_done_d;

    // A frame counts as done when its feature burst has been fully accepted.
    always_comb begin
        frames_done_d = frames_done_q;
        if (tag_pop) begin
            frames_done_d[tq.head] = frames_done_q[tq.head] + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frames_done_q <= '0;
        end else begin
            frames_done_q <= frames_done_d;
        end
    end

    assign frames_done_out = frames_done_q;
`else
    assign frames_done_out = '0;
`endif

endmodule

// File: tb/tb_feature_channel_arbiter.sv
`timescale 1ns/1ps
module tb_feature_channel_arbiter;
    import feature_pkg::*;

    localparam int NCH = 2;
    localparam int TD  = 4;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [NCH-1:0][FFT_W-1:0] ch_data;
    logic [NCH-1:0]            ch_valid, ch_last, ch_ready;
    logic [FFT_W-1:0]          ext_fft_data;
    logic                      ext_fft_valid, ext_fft_last, ext_fft_ready;
    logic signed [15:0]        ext_feat_data;
    logic                      ext_feat_valid, ext_feat_last, ext_feat_ready;
    logic [0:0]                feat_ch;
    logic                      tag_err;
    logic [NCH-1:0][15:0]      frames_done;

    feature_stream_if #(.W(FEATURE_W)) feat_if ();

    feature_channel_arbiter #(.NUM_CHANNELS(NCH), .TAG_DEPTH(TD)) dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .ch_fft_data_in        (ch_data),
        .ch_fft_valid_in       (ch_valid),
        .ch_fft_last_in        (ch_last),
        .ch_fft_ready_out      (ch_ready),
        .ext_fft_data_out      (ext_fft_data),
        .ext_fft_valid_out     (ext_fft_valid),
        .ext_fft_last_out      (ext_fft_last),
        .ext_fft_ready_in      (ext_fft_ready),
        .ext_feature_data_in   (ext_feat_data),
        .ext_feature_valid_in  (ext_feat_valid),
        .ext_feature_last_in   (ext_feat_last),
        .ext_feature_ready_out (ext_feat_ready),
        .feature_data_out      (feat_if.data),
        .feature_valid_out     (feat_if.valid),
        .feature_last_out      (feat_if.last),
        .feature_channel_out   (feat_ch),
        .feature_ready_in      (feat_if.ready),
        .tag_error_out         (tag_err),
        .frames_done_out       (frames_done)
    );

    int checks = 0;
    int failures = 0;

    // source model state
    int frames_left [NCH];
    int idx [NCH];
    int len [NCH];

    // observation logs
    int grant_log [$];
    int gap_log [$];
    int pop_log [$];
    int idle_run;
    bit seen_first;
    int mirror_err;
    int ch0_ready_seen;
    logic fv_s, efr_s;

    task automatic drive_sources();
        for (int c = 0; c < NCH; c++) begin
            ch_valid[c] = (frames_left[c] > 0);
            ch_data[c]  = (32'(c) << 24) | 32'(idx[c]);
            ch_last[c]  = (idx[c] == len[c] - 1);
        end
    endtask

    task automatic run_cycle();
        logic [NCH-1:0] hs;
        int g;
        drive_sources();
        @(negedge clk_in);
        hs = ch_valid & ch_ready;
        fv_s  = feat_if.valid;
        efr_s = ext_feat_ready;
        if (ch_ready[0]) ch0_ready_seen++;
        if (ext_fft_valid) begin
            g = -1;
            for (int c = 0; c < NCH; c++) if (ch_ready[c]) g = c;
            if ($countones(ch_ready) != 1 || g < 0) mirror_err++;
            else if (ext_fft_data !== ch_data[g] || ext_fft_last !== ch_last[g]) mirror_err++;
            if (ext_fft_ready && ext_fft_data[15:0] == 16'd0) begin
                grant_log.push_back(int'(ext_fft_data[31:24]));
                if (seen_first) gap_log.push_back(idle_run);
                seen_first = 1'b1;
                idle_run = 0;
            end
        end else begin
            if (ch_ready !== '0) mirror_err++;
            idle_run++;
        end
        if (feat_if.valid && feat_if.ready && feat_if.last) pop_log.push_back(int'(feat_ch));
        @(posedge clk_in);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (hs[c]) begin
                if (idx[c] == len[c] - 1) begin
                    idx[c] = 0;
                    frames_left[c]--;
                end else begin
                    idx[c]++;
                end
            end
        end
    endtask

    task automatic do_reset(input int flen);
        rst_n_in = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            frames_left[c] = 0;
            idx[c] = 0;
            len[c] = flen;
        end
        ext_fft_ready = 1'b1;
        ext_feat_data = 16'sd0;
        ext_feat_valid = 1'b0;
        ext_feat_last = 1'b0;
        feat_if.ready = 1'b1;
        grant_log.delete();
        gap_log.delete();
        pop_log.delete();
        idle_run = 0;
        seen_first = 1'b0;
        mirror_err = 0;
        ch0_ready_seen = 0;
        drive_sources();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // single-cycle feature burst of length 1 (valid+last)
    task automatic pop_one();
        ext_feat_valid = 1'b1;
        ext_feat_last = 1'b1;
        ext_feat_data = 16'sh0123;
        run_cycle();
        ext_feat_valid = 1'b0;
        ext_feat_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8);
        rst_n_in = 1'b0;
        frames_left[0] = 1;
        frames_left[1] = 1;
        drive_sources();
        #3;
        checks++; if (ch_ready !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", ch_ready); end
        checks++; if (ext_fft_valid !== 1'b0) begin failures++; $display("FAIL reset_ext_valid: got %b want 0", ext_fft_valid); end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
        checks++; if (frames_done !== '0) begin failures++; $display("FAIL reset_frames_done: got %h want 0", frames_done); end
        checks++; if (feat_if.valid !== 1'b0) begin failures++; $display("FAIL reset_feat_valid: got %b want 0", feat_if.valid); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        do_reset(512);
        frames_left[0] = 2;
        frames_left[1] = 2;
        while (grant_log.size() < 4 && cyc < 3000) begin
            run_cycle();
            cyc++;
        end
        checks++; if (grant_log.size() != 4) begin failures++; $display("FAIL rr_grants: got %0d want 4", grant_log.size()); end
        if (grant_log.size() == 4) begin
            checks++; if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
                failures++; $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 0 1", grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
            end
            checks++; if (gap_log.size() != 3 || gap_log[0] != 1 || gap_log[1] != 1 || gap_log[2] != 1) begin
                failures++; $display("FAIL rr_idle_gap: got size %0d first %0d want 3 gaps of 1", gap_log.size(), (gap_log.size() > 0) ? gap_log[0] : -1);
            end
        end
        checks++; if (mirror_err != 0) begin failures++; $display("FAIL rr_mirror: got %0d errors want 0", mirror_err); end
    endtask

    task automatic test_single_channel();
        int cyc = 0;
        do_reset(8);
        frames_left[1] = 3;
        while ((frames_left[1] > 0) && cyc < 200) begin
            run_cycle();
            cyc++;
        end
        checks++; if (grant_log.size() != 3 || grant_log[0] != 1 || grant_log[1] != 1 || grant_log[2] != 1) begin
            failures++; $display("FAIL single_ch1_grants: got %0d grants want 3 of ch1", grant_log.size());
        end
        checks++; if (ch0_ready_seen != 0) begin failures++; $display("FAIL single_ch0_ready: got %0d cycles want 0", ch0_ready_seen); end
        checks++; if (mirror_err != 0) begin failures++; $display("FAIL single_mirror: got %0d errors want 0", mirror_err); end
    endtask

    task automatic test_tag_full();
        int cyc = 0;
        int ch_err = 0;
        do_reset(8);
        frames_left[0] = 3;
        frames_left[1] = 2;
        repeat (80) run_cycle();
        checks++; if (grant_log.size() != 4) begin failures++; $display("FAIL full_blocked: got %0d grants want 4", grant_log.size()); end
        checks++; if (ch_ready !== 2'b00 || ext_fft_valid !== 1'b0) begin
            failures++; $display("FAIL full_idle: got ready %b valid %b want 00 0", ch_ready, ext_fft_valid);
        end
        // 16-feature burst for the oldest frame
        for (int i = 0; i < 16; i++) begin
            ext_feat_valid = 1'b1;
            ext_feat_last = (i == 15);
            ext_feat_data = 16'(i);
            if (feat_ch !== 1'b0) ch_err++;
            run_cycle();
        end
        ext_feat_valid = 1'b0;
        ext_feat_last = 1'b0;
        checks++; if (ch_err != 0 || pop_log.size() != 1) begin
            failures++; $display("FAIL full_burst: got ch_err %0d pops %0d want 0 1", ch_err, pop_log.size());
        end
        while (grant_log.size() < 5 && cyc < 50) begin
            run_cycle();
            cyc++;
        end
        checks++; if (grant_log.size() != 5 || grant_log[4] != 0) begin
            failures++; $display("FAIL full_fifth_grant: got %0d grants want 5 ending ch0", grant_log.size());
        end
        repeat (12) run_cycle();
        repeat (4) pop_one();
        checks++; if (pop_log.size() != 5 || pop_log[0] != 0 || pop_log[1] != 1 || pop_log[2] != 0 || pop_log[3] != 1 || pop_log[4] != 0) begin
            failures++; $display("FAIL full_tag_order: got %0d pops want order 0 1 0 1 0", pop_log.size());
        end
    endtask

    task automatic test_push_pop();
        int cyc = 0;
        do_reset(8);
        frames_left[0] = 1;
        frames_left[1] = 1;
        while ((frames_left[0] + frames_left[1]) > 0 && cyc < 100) begin
            run_cycle();
            cyc++;
        end
        run_cycle();
        // occupancy 2 (tags 0,1); grant ch0 and pop tag 0 on the same edge
        frames_left[0] = 1;
        pop_one();
        checks++; if (pop_log.size() != 1 || pop_log[0] != 0) begin
            failures++; $display("FAIL pp_first_pop: got %0d pops want 1 of ch0", pop_log.size());
        end
        repeat (12) run_cycle();
        checks++; if (grant_log.size() != 3 || grant_log[2] != 0) begin
            failures++; $display("FAIL pp_push: got %0d grants want 3 ending ch0", grant_log.size());
        end
        pop_one();
        pop_one();
        checks++; if (pop_log.size() != 3 || pop_log[1] != 1 || pop_log[2] != 0) begin
            failures++; $display("FAIL pp_remaining: got %0d pops want tags 1 then 0", pop_log.size());
        end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL pp_no_err: got %b want 0", tag_err); end
        pop_one();
        checks++; if (fv_s !== 1'b0) begin failures++; $display("FAIL pp_empty_after2: got valid %b want 0", fv_s); end
    endtask

    task automatic test_tag_error();
        do_reset(8);
        feat_if.ready = 1'b0;
        ext_feat_valid = 1'b1;
        ext_feat_last = 1'b0;
        run_cycle();
        ext_feat_valid = 1'b0;
        checks++; if (fv_s !== 1'b0) begin failures++; $display("FAIL err_feat_valid: got %b want 0", fv_s); end
        checks++; if (efr_s !== 1'b1) begin failures++; $display("FAIL err_ext_ready: got %b want 1", efr_s); end
        checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", tag_err); end
        repeat (5) run_cycle();
        checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", tag_err); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc = 0;
        logic [15:0] want0;
        do_reset(512);
        frames_left[0] = 1;
        while (idx[0] < 200 && cyc < 600) begin
            run_cycle();
            cyc++;
        end
        drive_sources();
        checks++; if (ext_fft_valid !== 1'b1 || idx[0] != 200) begin
            failures++; $display("FAIL mid_streaming: got valid %b idx %0d want 1 200", ext_fft_valid, idx[0]);
        end
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (ch_ready !== 2'b00 || ext_fft_valid !== 1'b0) begin
            failures++; $display("FAIL mid_async_reset: got ready %b valid %b want 00 0", ch_ready, ext_fft_valid);
        end
        do_reset(8);
        pop_one();
        checks++; if (fv_s !== 1'b0 || tag_err !== 1'b1) begin
            failures++; $display("FAIL mid_tags_dropped: got valid %b err %b want 0 1", fv_s, tag_err);
        end
        // frame counting over three ch0 frames
        do_reset(8);
        frames_left[0] = 3;
        cyc = 0;
        while (frames_left[0] > 0 && cyc < 100) begin
            run_cycle();
            cyc++;
        end
        repeat (3) pop_one();
`ifdef FEATURE_ARB_FRAME_COUNT_EN
        want0 = 16'd3;
`else
        want0 = 16'd0;
`endif
        checks++; if (frames_done[0] !== want0) begin failures++; $display("FAIL count_ch0: got %0d want %0d", frames_done[0], want0); end
        checks++; if (frames_done[1] !== 16'd0) begin failures++; $display("FAIL count_ch1: got %0d want 0", frames_done[1]); end
    endtask

    initial begin
        ext_fft_ready = 1'b1;
        ext_feat_valid = 1'b0;
        ext_feat_last = 1'b0;
        ext_feat_data = 16'sd0;
        feat_if.ready = 1'b1;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_tag_full();
        test_push_pop();
        test_tag_error();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
